// File: rtl/mem_loader_pkg.sv
// mem_loader_pkg: shared types and constants for the memory loader.
//   state_e          - loader FSM states
//   DefaultDigiAddr  - default address of the digit peripheral register
//   LaneFirst/Last   - byte-lane indices within a packed word (lane 0 = [31:24])
//   lane_shift()     - left-shift amount that places a byte into a lane
package mem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StPack,
        StWrite,
        StVerify,
        StReport,
        StDone
    } state_e;

    localparam logic [31:0] DefaultDigiAddr = 32'h4000_0010;

    localparam logic [1:0] LaneFirst = 2'd0;
    localparam logic [1:0] LaneLast  = 2'd3;

    // Big-endian packing: lane 0 lands in [31:24], lane 3 in [7:0].
    function automatic logic [4:0] lane_shift(input logic [1:0] lane);
        return 5'd24 - {lane, 3'b000};
    endfunction

endpackage

// File: rtl/mem_loader_if.sv
// mem_loader_if: single-cycle data-memory port shared through the bus mux.
//   Address    - byte address
//   Write_data - write data
//   MemWrite   - write strobe
//   MemRead    - read strobe
//   Read_data  - read data, combinational from memory in the same cycle
// Modports: master (bus initiator), slave (memory side).
interface mem_loader_if;

    logic [31:0] Address;
    logic [31:0] Write_data;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] Read_data;

    modport master (
        output Address,
        output Write_data,
        output MemWrite,
        output MemRead,
        input  Read_data
    );

    modport slave (
        input  Address,
        input  Write_data,
        input  MemWrite,
        input  MemRead,
        output Read_data
    );

endinterface

// File: rtl/mem_loader_word_packer.sv
// word_packer: packs a byte stream big-endian into 32-bit words.
//   clk, reset - clock and synchronous active-high reset
//   clear      - drop any partial word and restart at lane 0
//   load       - accept byte_in into the current lane this cycle
//   byte_in    - stream byte
//   last       - byte_in is the final byte of the stream
//   word       - packed word including the byte being loaded this cycle
//   word_full  - the byte being loaded completes the word (lane 3 or last)
// Lanes not yet filled stay zero, so a word closed early by last is zero-padded.
module word_packer
    import mem_loader_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clear,
    input  logic        load,
    input  logic [7:0]  byte_in,
    input  logic        last,
    output logic [31:0] word,
    output logic        word_full
);

    logic [1:0]  lane_q;
    logic [31:0] pack_q;

    // Merge the incoming byte combinationally so the write can issue in the next cycle.
    always_comb begin
        word = pack_q;
        if (load) begin
            word = pack_q | (32'(byte_in) << lane_shift(lane_q));
        end
    end

    assign word_full = load && ((lane_q == LaneLast) || last);

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            lane_q <= LaneFirst;
            pack_q <= '0;
        end else if (load) begin
            if (word_full) begin
                lane_q <= LaneFirst;
                pack_q <= '0;
            end else begin
                lane_q <= lane_q + 2'd1;
                pack_q <= word;
            end
        end
    end

endmodule

// File: rtl/mem_loader.sv
// mem_loader: fills data memory from a byte stream, then reports the word count.
//   clk, reset   - clock and synchronous active-high reset
//   start        - pulse to begin a load (ignored while busy)
//   byte_in/byte_valid/byte_last/byte_ready - byte stream handshake
//   bus          - data-memory port (mem_loader_if.master)
//   busy         - load in progress
//   done         - one-cycle pulse on completion
//   error        - sticky: overflow or verify mismatch; cleared by start
//   word_count   - words written in the current or last load
// Optional: define LOADER_VERIFY_EN to read back each written word and compare.
// All outputs are registered.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int unsigned WORD_COUNT_MAX = 512,
    parameter logic [31:0] DIGI_ADDR      = DefaultDigiAddr
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [7:0]          byte_in,
    input  logic                byte_valid,
    input  logic                byte_last,
    output logic                byte_ready,
    mem_loader_if.master        bus,
    output logic                busy,
    output logic                done,
    output logic                error,
    output logic [9:0]          word_count
);

    localparam logic [9:0] MaxCount = 10'(WORD_COUNT_MAX);

    state_e      state;
    logic        last_q;
    logic        load;
    logic        word_full;
    logic [31:0] word;

    assign load = byte_valid && byte_ready;

    word_packer u_packer (
        .clk       (clk),
        .reset     (reset),
        .clear     (state == StIdle),
        .load      (load),
        .byte_in   (byte_in),
        .last      (byte_last),
        .word      (word),
        .word_full (word_full)
    );

`ifdef LOADER_VERIFY_EN
    logic [31:0] word_q;
`else
    logic unused_read;
    assign unused_read = ^bus.Read_data;
    assign bus.MemRead = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= StIdle;
            last_q         <= 1'b0;
            byte_ready     <= 1'b0;
            bus.Address    <= '0;
            bus.Write_data <= '0;
            bus.MemWrite   <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            word_count     <= '0;
`ifdef LOADER_VERIFY_EN
            bus.MemRead    <= 1'b0;
            word_q         <= '0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    done <= 1'b0;
                    if (start) begin
                        state      <= StPack;
                        byte_ready <= 1'b1;
                        busy       <= 1'b1;
                        word_count <= '0;
                        error      <= 1'b0;
                    end
                end

                StPack: begin
                    if (word_full) begin
                        if (word_count == MaxCount) begin
                            // Memory full: discard the word, keep draining until last.
                            error <= 1'b1;
                            if (byte_last) begin
                                state          <= StReport;
                                byte_ready     <= 1'b0;
                                bus.MemWrite   <= 1'b1;
                                bus.Address    <= DIGI_ADDR;
                                bus.Write_data <= {22'b0, word_count};
                            end
                        end else begin
                            state          <= StWrite;
                            byte_ready     <= 1'b0;
                            last_q         <= byte_last;
                            bus.MemWrite   <= 1'b1;
                            bus.Address    <= BASE_ADDR + {20'b0, word_count, 2'b00};
                            bus.Write_data <= word;
`ifdef LOADER_VERIFY_EN
                            word_q         <= word;
`endif
                        end
                    end
                end

                StWrite: begin
                    word_count <= word_count + 10'd1;
`ifdef LOADER_VERIFY_EN
                    // Address is held for the read-back.
                    state          <= StVerify;
                    bus.MemWrite   <= 1'b0;
                    bus.MemRead    <= 1'b1;
                    bus.Write_data <= '0;
`else
                    if (last_q) begin
                        state          <= StReport;
                        bus.MemWrite   <= 1'b1;
                        bus.Address    <= DIGI_ADDR;
                        bus.Write_data <= {22'b0, word_count + 10'd1};
                    end else begin
                        state          <= StPack;
                        byte_ready     <= 1'b1;
                        bus.MemWrite   <= 1'b0;
                        bus.Address    <= '0;
                        bus.Write_data <= '0;
                    end
`endif
                end

`ifdef LOADER_VERIFY_EN
                StVerify: begin
                    bus.MemRead <= 1'b0;
                    if (bus.Read_data != word_q) begin
                        error <= 1'b1;
                    end
                    if (last_q) begin
                        state          <= StReport;
                        bus.MemWrite   <= 1'b1;
                        bus.Address    <= DIGI_ADDR;
                        bus.Write_data <= {22'b0, word_count};
                    end else begin
                        state          <= StPack;
                        byte_ready     <= 1'b1;
                        bus.Address    <= '0;
                        bus.Write_data <= '0;
                    end
                end
`endif

                StReport: begin
                    state          <= StDone;
                    bus.MemWrite   <= 1'b0;
                    bus.Address    <= '0;
                    bus.Write_data <= '0;
                    busy           <= 1'b0;
                    done           <= 1'b1;
                end

                StDone: begin
                    state <= StIdle;
                    done  <= 1'b0;
                end

                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_loader.sv
// tb_mem_loader: scoreboard bench for mem_loader with a behavioural stream model.
module tb_mem_loader;

    localparam logic [31:0] BaseAddr = 32'h0000_0000;
    localparam int unsigned MaxWords = 512;
    localparam logic [31:0] DigiAddr = 32'h4000_0010;
`ifdef LOADER_VERIFY_EN
    localparam int VerifyCyc = 1;
`else
    localparam int VerifyCyc = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] byte_in;
    logic       byte_valid;
    logic       byte_last;
    logic       byte_ready;
    logic       busy;
    logic       done;
    logic       error;
    logic [9:0] word_count;

    mem_loader_if bus ();

    mem_loader #(
        .BASE_ADDR      (BaseAddr),
        .WORD_COUNT_MAX (MaxWords),
        .DIGI_ADDR      (DigiAddr)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .byte_last  (byte_last),
        .byte_ready (byte_ready),
        .bus        (bus),
        .busy       (busy),
        .done       (done),
        .error      (error),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    // Simple memory model behind the port; read data optionally corrupted.
    logic [31:0] mem [0:511];
    logic        corrupt_en = 1'b0;

    always @(posedge clk) begin
        if (bus.MemWrite && (bus.Address < 32'h800)) begin
            mem[bus.Address[10:2]] <= bus.Write_data;
        end
    end

    assign bus.Read_data = (corrupt_en && bus.MemRead) ? 32'hDEAD_BEEF
                                                        : mem[bus.Address[10:2]];

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] data;
    } wr_t;

    wr_t        exp_q[$];
    wr_t        mon_e;
    logic [7:0] stream[$];
    int         n_tests = 0;
    int         n_fail = 0;
    int         cyc = 0;
    int         done_cnt = 0;
    int         done_cyc = 0;
    logic [31:0] last_wr_addr = '0;

    function automatic void check(input string name, input logic [31:0] act,
                                  input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
        end
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every bus write must match the head of the expected queue.
    always @(negedge clk) begin
        if (bus.MemWrite) begin
            check("no_overlap", {31'b0, bus.MemRead}, 32'd0);
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: addr 0x%08h data 0x%08h expected none",
                         bus.Address, bus.Write_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("wr_addr", bus.Address, mon_e.addr);
                check("wr_data", bus.Write_data, mon_e.data);
            end
            last_wr_addr = bus.Address;
        end else if (bus.MemRead) begin
`ifdef LOADER_VERIFY_EN
            check("rd_addr", bus.Address, last_wr_addr);
`else
            check("memread_off", {31'b0, bus.MemRead}, 32'd0);
`endif
        end else begin
            check("idle_addr", bus.Address, 32'd0);
            check("idle_data", bus.Write_data, 32'd0);
        end
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    // Reference model: words from the stream, capacity limit, report, cycle cost.
    task automatic build_expect(input bit corrupt, output int s_exp,
                                output logic [9:0] exp_wc, output logic exp_err);
        int n;
        int nw;
        int written;
        wr_t e;
        n = stream.size();
        nw = (n + 3) / 4;
        written = (nw > int'(MaxWords)) ? int'(MaxWords) : nw;
        s_exp = 1;
        for (int w = 0; w < nw; w++) begin
            logic [31:0] wd;
            int nb;
            wd = '0;
            nb = 0;
            for (int j = 0; j < 4; j++) begin
                if (w * 4 + j < n) begin
                    wd = wd | (32'(stream[w * 4 + j]) << (24 - 8 * j));
                    nb++;
                end
            end
            if (w < int'(MaxWords)) begin
                e.addr = BaseAddr + 32'(4 * w);
                e.data = wd;
                exp_q.push_back(e);
                s_exp += nb + 1 + VerifyCyc;
            end else begin
                s_exp += nb;
            end
        end
        e.addr = DigiAddr;
        e.data = 32'(written);
        exp_q.push_back(e);
        exp_wc = 10'(written);
        exp_err = (nw > int'(MaxWords)) || (corrupt && (VerifyCyc == 1) && (written > 0));
    endtask

    task automatic run_load(input int gap_pct, input bit mid_start, input bit corrupt);
        int s_exp;
        int stalls;
        int idx;
        int n;
        int start_cyc;
        int guard;
        logic [9:0] ewc;
        logic eerr;
        bit hs;
        stalls = 0;
        idx = 0;
        n = stream.size();
        build_expect(corrupt, s_exp, ewc, eerr);
        corrupt_en = corrupt;
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        start_cyc = cyc;
        check("busy_after_start", {31'b0, busy}, 32'd1);
        check("ready_latency", {31'b0, byte_ready}, 32'd1);
        guard = 0;
        while (idx < n && guard < 20000) begin
            start = mid_start && busy && ($urandom_range(15) == 0);
            if (byte_ready) begin
                if ($urandom_range(99) >= gap_pct) begin
                    byte_valid = 1'b1;
                    byte_in    = stream[idx];
                    byte_last  = (idx == n - 1);
                end else begin
                    byte_valid = 1'b0;
                    byte_in    = 8'($urandom);
                    byte_last  = 1'($urandom);
                    stalls++;
                end
            end else begin
                byte_valid = 1'($urandom);
                byte_in    = 8'($urandom);
                byte_last  = 1'($urandom);
            end
            hs = byte_valid && byte_ready;
            @(posedge clk); #1;
            if (hs) idx++;
            guard++;
        end
        start = 1'b0;
        byte_valid = 1'b0;
        byte_last = 1'b0;
        if (idx < n) begin
            n_tests++;
            n_fail++;
            $display("FAIL stream_timeout: accepted %0d bytes expected %0d", idx, n);
        end
        guard = 0;
        while (done_cnt == 0 && guard < 200) begin
            @(posedge clk); #1;
            guard++;
        end
        repeat (3) @(posedge clk);
        #1;
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("load_cycles", 32'(done_cyc - start_cyc), 32'(s_exp + stalls));
        check("word_count", {22'b0, word_count}, {22'b0, ewc});
        check("error", {31'b0, error}, {31'b0, eerr});
        check("busy_end", {31'b0, busy}, 32'd0);
        check("pending_writes", 32'(exp_q.size()), 32'd0);
        exp_q.delete();
        corrupt_en = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_ready"}, {31'b0, byte_ready}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
        check({tag, "_error"}, {31'b0, error}, 32'd0);
        check({tag, "_wc"}, {22'b0, word_count}, 32'd0);
        check({tag, "_memwrite"}, {31'b0, bus.MemWrite}, 32'd0);
        check({tag, "_memread"}, {31'b0, bus.MemRead}, 32'd0);
        check({tag, "_addr"}, bus.Address, 32'd0);
        check({tag, "_wdata"}, bus.Write_data, 32'd0);
    endtask

    task automatic rand_stream(input int len);
        stream.delete();
        for (int i = 0; i < len; i++) stream.push_back(8'($urandom));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = '0;
        reset = 1'b1;
        start = 1'b0;
        byte_in = '0;
        byte_valid = 1'b0;
        byte_last = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        reset = 1'b0;
        @(posedge clk); #1;

        stream = {8'h6c, 8'h69, 8'h6e, 8'h75, 8'h78, 8'h20, 8'h69, 8'h73};
        run_load(0, 1'b0, 1'b0);

        stream = {8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        run_load(0, 1'b0, 1'b0);

        for (int t = 0; t < 6; t++) begin
            rand_stream($urandom_range(40, 1));
            run_load(30, 1'b1, 1'b0);
        end

        // Abort with two bytes pending in the packer.
        done_cnt = 0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        byte_valid = 1'b1;
        byte_last = 1'b0;
        byte_in = 8'hAA;
        @(posedge clk); #1;
        byte_in = 8'hBB;
        @(posedge clk); #1;
        byte_valid = 1'b0;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check_all_zero("abort");
        repeat (3) @(posedge clk);
        #1;
        check("abort_idle_ready", {31'b0, byte_ready}, 32'd0);
        check("abort_no_done", 32'(done_cnt), 32'd0);
        rand_stream(6);
        run_load(20, 1'b0, 1'b0);

        // Overflow: one word more than the memory holds.
        rand_stream(513 * 4);
        run_load(0, 1'b1, 1'b0);

        // Exactly full, and start must clear the previous sticky error.
        rand_stream(512 * 4);
        run_load(0, 1'b0, 1'b0);

`ifdef LOADER_VERIFY_EN
        stream = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_load(0, 1'b0, 1'b1);
`endif

        rand_stream(9);
        run_load(10, 1'b1, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
